ram_arbiter_2p: RTL and testbench
=================================

Name: ram_arbiter_2p

Overview:
- Two-port arbiter/sequencer that shares one 16K x 16 RAM (the ram16k macro) between requesters A and B.
- Accepts one word read or write per grant and drives the RAM's w/r/en/add/d_in from registered signals.
- Captures read data and returns a one-cycle acknowledge to the served requester.
- Sits between the RAM array and its two bus masters.

Parameters:
- AW, 14, address width; matches the RAM address bus.
- DW, 16, data width.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  requester A command valid; held until a_ack.
- a_we  in  1  A: 1 = write, 0 = read.
- a_addr  in  AW  A word address.
- a_wdata  in  DW  A write data.
- a_ack  out  1  one-cycle completion pulse to A.
- a_rdata  out  DW  A read data; valid while a_ack=1 for a read.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as A, for requester B.
- ram_w  out  1  RAM write strobe.
- ram_r  out  1  RAM read strobe.
- ram_en  out  1  RAM chip enable.
- ram_add  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data; combinational, high-Z unless ram_r & ram_en.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM forced to IDLE.
  - All outputs 0: acks, rdata, ram_w/r/en, ram_add, ram_din, busy.
  - last_gnt := B, so A wins the first contention.
  - RAM contents are untouched.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - No req: stay in IDLE; RAM outputs 0.
  - Exactly one req: grant that requester.
  - Both req: grant the requester not equal to last_gnt (round-robin).
  - On grant, at the edge: register we/addr/wdata of the winner into ram_w/ram_r/ram_add/ram_din, set ram_en=1, set last_gnt to the winner, go to EXEC.
- EXEC (one cycle): RAM sees stable en/add/w/r/din for the full cycle.
  - Write: the RAM commits at the closing rising edge.
  - Read: ram_dout is sampled at the closing edge into the winner's rdata register.
  - At that edge: ram_en/w/r := 0, winner's ack := 1, go to RESP.
- RESP (one cycle):
  - Winner's ack=1 and rdata valid (read only).
  - Next edge: ack := 0, go to IDLE unconditionally.
- Timing:
  - A request sampled at edge N gives EXEC in cycle N+1 and ack in cycle N+2.
  - Maximum throughput is one access per 3 cycles.
- Requester protocol:
  - Holds req/we/addr/wdata stable until it sees ack.
  - May keep req high after ack to issue a new command; it is re-arbitrated in the next IDLE cycle.
- Data hold rules:
  - rdata of a requester holds its last read value until that requester's next read completes.
  - Writes do not alter rdata.
- Exclusivity: ram_w and ram_r are never both 1; a_ack and b_ack are never both 1.
- Command sampling: changes to req or command inputs during EXEC/RESP are ignored; the command is sampled only in IDLE.
- Reset mid-operation: if rst_n falls during EXEC, ram_en drops immediately, no ack is issued, and the write may be lost.
- Address range: all 2^AW addresses are legal; no wrap or range checking.

Optional Feature:
- ARB_FIXED_PRIO_EN
  - Defined: fixed priority; A always wins when both request. last_gnt still updates but is unused.
  - Undefined (default): round-robin as above.

Test Plan:
- Reset, then A write addr 0x0005 data 0xBEEF, then A read 0x0005.
  - a_ack pulses 2 cycles after each req sample.
  - a_rdata=0xBEEF on the read ack.
  - b_ack stays 0 throughout.
- A and B request in the same cycle: A writes 0x1234 to 0x3FFF, B reads 0x3FFF.
  - A is served first (last_gnt=B after reset); B follows.
  - b_rdata=0x1234.
- Both requesters hold req high for 4 back-to-back accesses each.
  - Acks alternate A, B, A, B, ...
  - Each access is 3 cycles; ram_w&ram_r is never 1.
  - With ARB_FIXED_PRIO_EN defined: all 4 A accesses complete before any B access.
- B reads 0x2000 holding 0x00AA, then B writes 0x2000 with 0x5555.
  - b_rdata remains 0x00AA after the write ack.
  - A subsequent read returns 0x5555.
- Assert rst_n=0 mid-EXEC of an A write of 0xFFFF to 0x0100 that holds 0x0000.
  - All outputs 0 immediately; no a_ack.
  - After release, a read of 0x0100 returns either 0x0000 or 0xFFFF, with no X.
  - The FSM returns to IDLE with busy=0.

Source files
------------

// File: rtl/ram_arbiter_2p_if.sv
// Requester-side command/response bundle for ram_arbiter_2p: one instance per bus master.
// The master drives req/we/addr/wdata and receives ack/rdata; the arbiter uses the slave view.
interface ram_arbiter_2p_if #(
  parameter int AW = 14,
  parameter int DW = 16
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter_2p.sv
// Two-port sequencer sharing one single-port 16K x 16 RAM between requesters A and B.
// Contention is round-robin by default; defining ARB_FIXED_PRIO_EN makes A always win.
module ram_arbiter_2p #(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_arbiter_2p_if.slave a,
  ram_arbiter_2p_if.slave b,
  output logic            ram_w,
  output logic            ram_r,
  output logic            ram_en,
  output logic [AW-1:0]   ram_add,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic          last_gnt_r;   // 1'b1 = B was served last
  logic          gnt_r;        // requester owning the current access, 1'b1 = B
  logic          ram_w_r;
  logic          ram_r_r;
  logic          ram_en_r;
  logic [AW-1:0] ram_add_r;
  logic [DW-1:0] ram_din_r;
  logic          a_ack_r;
  logic          b_ack_r;
  logic [DW-1:0] a_rdata_r;
  logic [DW-1:0] b_rdata_r;
  logic          busy_r;

  logic          req_any_s;
  logic          pick_b_s;
  logic          win_we_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_wdata_s;

  // Choose the winner among the IDLE-cycle requests and mux its command.
  always_comb begin
    req_any_s   = a.req | b.req;
    pick_b_s    = 1'b0;
    win_we_s    = 1'b0;
    win_addr_s  = {AW{1'b0}};
    win_wdata_s = {DW{1'b0}};
    if (a.req && b.req) begin
`ifdef ARB_FIXED_PRIO_EN
      pick_b_s = 1'b0;
`else
      pick_b_s = ~last_gnt_r;
`endif
    end else if (b.req) begin
      pick_b_s = 1'b1;
    end else begin
      pick_b_s = 1'b0;
    end
    if (pick_b_s) begin
      win_we_s    = b.we;
      win_addr_s  = b.addr;
      win_wdata_s = b.wdata;
    end else begin
      win_we_s    = a.we;
      win_addr_s  = a.addr;
      win_wdata_s = a.wdata;
    end
  end

  // Sequencer FSM: IDLE grants, EXEC holds the RAM access for one cycle, RESP presents the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      last_gnt_r <= 1'b1;
      gnt_r      <= 1'b0;
      ram_w_r    <= 1'b0;
      ram_r_r    <= 1'b0;
      ram_en_r   <= 1'b0;
      ram_add_r  <= {AW{1'b0}};
      ram_din_r  <= {DW{1'b0}};
      a_ack_r    <= 1'b0;
      b_ack_r    <= 1'b0;
      a_rdata_r  <= {DW{1'b0}};
      b_rdata_r  <= {DW{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          a_ack_r <= 1'b0;
          b_ack_r <= 1'b0;
          if (req_any_s) begin
            ram_en_r   <= 1'b1;
            ram_w_r    <= win_we_s;
            ram_r_r    <= ~win_we_s;
            ram_add_r  <= win_addr_s;
            ram_din_r  <= win_wdata_s;
            gnt_r      <= pick_b_s;
            last_gnt_r <= pick_b_s;
            busy_r     <= 1'b1;
            state_r    <= EXEC;
          end else begin
            ram_en_r  <= 1'b0;
            ram_w_r   <= 1'b0;
            ram_r_r   <= 1'b0;
            ram_add_r <= {AW{1'b0}};
            ram_din_r <= {DW{1'b0}};
            busy_r    <= 1'b0;
          end
        end
        EXEC: begin
          // Read data is captured on the same edge that closes the RAM access.
          if (ram_r_r && gnt_r) begin
            b_rdata_r <= ram_dout;
          end else if (ram_r_r) begin
            a_rdata_r <= ram_dout;
          end else begin
            b_rdata_r <= b_rdata_r;
          end
          a_ack_r   <= ~gnt_r;
          b_ack_r   <= gnt_r;
          ram_en_r  <= 1'b0;
          ram_w_r   <= 1'b0;
          ram_r_r   <= 1'b0;
          ram_add_r <= {AW{1'b0}};
          ram_din_r <= {DW{1'b0}};
          state_r   <= RESP;
        end
        RESP: begin
          a_ack_r <= 1'b0;
          b_ack_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          a_ack_r   <= 1'b0;
          b_ack_r   <= 1'b0;
          ram_en_r  <= 1'b0;
          ram_w_r   <= 1'b0;
          ram_r_r   <= 1'b0;
          ram_add_r <= {AW{1'b0}};
          ram_din_r <= {DW{1'b0}};
          busy_r    <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign ram_w   = ram_w_r;
  assign ram_r   = ram_r_r;
  assign ram_en  = ram_en_r;
  assign ram_add = ram_add_r;
  assign ram_din = ram_din_r;
  assign a.ack   = a_ack_r;
  assign b.ack   = b_ack_r;
  assign a.rdata = a_rdata_r;
  assign b.rdata = b_rdata_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural 16K x 16 RAM behind it.
module tb_ram_arbiter_2p;

  logic        clk;
  logic        rst_n;
  logic        ram_w, ram_r, ram_en, busy;
  logic [13:0] ram_add;
  logic [15:0] ram_din;
  wire  [15:0] ram_dout;

  logic        pl_en;
  logic [13:0] pl_addr;
  logic [15:0] pl_data;
  logic [15:0] mem [0:16383] = '{default: 16'h0000};

  int n_cmp = 0;
  int n_bad = 0;

  ram_arbiter_2p_if #(.AW(14), .DW(16)) a_if ();
  ram_arbiter_2p_if #(.AW(14), .DW(16)) b_if ();

  ram_arbiter_2p #(.AW(14), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a_if), .b(b_if),
    .ram_w(ram_w), .ram_r(ram_r), .ram_en(ram_en), .ram_add(ram_add),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read, plus a bench-side preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ram_en && ram_w) mem[ram_add] <= ram_din;
  end
  assign ram_dout = (ram_r && ram_en) ? mem[ram_add] : 16'hzzzz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = 14'h0; a_if.wdata = 16'h0;
    b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = 14'h0; b_if.wdata = 16'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    pl_en = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic preload(input logic [13:0] addr, input logic [15:0] data);
    pl_addr = addr; pl_data = data; pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  // Returns the number of ticks until the chosen ack is seen, 0 if none within the budget.
  task automatic wait_ack(input bit port_b, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if ((port_b ? b_if.ack : a_if.ack) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    pl_en = 1'b0;
    tick();
    n_cmp++;
    if ({ram_w, ram_r, ram_en, busy, a_if.ack, b_if.ack} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {ram_w, ram_r, ram_en, busy, a_if.ack, b_if.ack});
    end
    n_cmp++;
    if ({ram_add, ram_din} !== 30'h0) begin
      n_bad++; $display("FAIL reset_bus: got add=%h din=%h want 0", ram_add, ram_din);
    end
    n_cmp++;
    if ({a_if.rdata, b_if.rdata} !== 32'h0) begin
      n_bad++; $display("FAIL reset_rdata: got a=%h b=%h want 0", a_if.rdata, b_if.rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_a();
    int cyc;
    do_reset();
    a_if.we = 1'b1; a_if.addr = 14'h0005; a_if.wdata = 16'hBEEF; a_if.req = 1'b1;
    tick();
    n_cmp++;
    if ({busy, ram_en, ram_w, ram_r, ram_add, ram_din} !== {4'b1110, 14'h0005, 16'hBEEF}) begin
      n_bad++; $display("FAIL exec_wr: got en=%b w=%b r=%b add=%h din=%h busy=%b", ram_en, ram_w, ram_r, ram_add, ram_din, busy);
    end
    tick();
    n_cmp++;
    if ({a_if.ack, b_if.ack, ram_en} !== 3'b100) begin
      n_bad++; $display("FAIL wr_ack: got a_ack=%b b_ack=%b en=%b want 1 0 0", a_if.ack, b_if.ack, ram_en);
    end
    a_if.req = 1'b0;
    tick();
    n_cmp++;
    if ({a_if.ack, busy, mem[14'h0005]} !== {2'b00, 16'hBEEF}) begin
      n_bad++; $display("FAIL wr_done: got ack=%b busy=%b mem=%h want 0 0 beef", a_if.ack, busy, mem[14'h0005]);
    end
    a_if.we = 1'b0; a_if.req = 1'b1;
    wait_ack(1'b0, cyc);
    n_cmp++;
    if (cyc !== 2) begin
      n_bad++; $display("FAIL rd_latency: got %0d want 2", cyc);
    end
    n_cmp++;
    if ({a_if.rdata, b_if.ack} !== {16'hBEEF, 1'b0}) begin
      n_bad++; $display("FAIL rd_data: got rdata=%h b_ack=%b want beef 0", a_if.rdata, b_if.ack);
    end
    a_if.req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int cyc;
    do_reset();
    a_if.we = 1'b1; a_if.addr = 14'h3FFF; a_if.wdata = 16'h1234;
    b_if.we = 1'b0; b_if.addr = 14'h3FFF;
    a_if.req = 1'b1; b_if.req = 1'b1;
    wait_ack(1'b0, cyc);
    n_cmp++;
    if (cyc !== 2 || b_if.ack !== 1'b0) begin
      n_bad++; $display("FAIL cont_first: got a latency=%0d b_ack=%b want 2 0", cyc, b_if.ack);
    end
    a_if.req = 1'b0;
    wait_ack(1'b1, cyc);
    n_cmp++;
    if (cyc !== 3) begin
      n_bad++; $display("FAIL cont_second: got b latency=%0d want 3", cyc);
    end
    n_cmp++;
    if (b_if.rdata !== 16'h1234) begin
      n_bad++; $display("FAIL cont_rdata: got %h want 1234", b_if.rdata);
    end
    b_if.req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int a_done, b_done, k, last_cyc, gap_bad, excl_bad;
    logic [7:0] ord, exp_ord;
    a_done = 0; b_done = 0; k = 0; last_cyc = 0; gap_bad = 0; excl_bad = 0; ord = 8'h00;
`ifdef ARB_FIXED_PRIO_EN
    exp_ord = 8'b1111_0000;
`else
    exp_ord = 8'b1010_1010;
`endif
    do_reset();
    a_if.we = 1'b1; a_if.addr = 14'h0200; a_if.wdata = 16'hA000;
    b_if.we = 1'b1; b_if.addr = 14'h0300; b_if.wdata = 16'hB000;
    a_if.req = 1'b1; b_if.req = 1'b1;
    for (int cyc = 1; cyc <= 40 && k < 8; cyc++) begin
      tick();
      if (ram_w && ram_r) excl_bad++;
      if (a_if.ack && b_if.ack) excl_bad++;
      if (a_if.ack || b_if.ack) begin
        if (cyc - last_cyc != ((k == 0) ? 2 : 3)) gap_bad++;
        last_cyc = cyc;
        ord[k] = b_if.ack;
        k++;
      end
      if (a_if.ack) begin
        a_done++;
        if (a_done == 4) a_if.req = 1'b0;
        else begin a_if.addr = 14'h0200 + 14'(a_done); a_if.wdata = 16'hA000 + 16'(a_done); end
      end
      if (b_if.ack) begin
        b_done++;
        if (b_done == 4) b_if.req = 1'b0;
        else begin b_if.addr = 14'h0300 + 14'(b_done); b_if.wdata = 16'hB000 + 16'(b_done); end
      end
    end
    n_cmp++;
    if (k !== 8 || ord !== exp_ord) begin
      n_bad++; $display("FAIL b2b_order: got %0d acks order=%b want 8 order=%b", k, ord, exp_ord);
    end
    n_cmp++;
    if (gap_bad !== 0) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad);
    end
    n_cmp++;
    if (excl_bad !== 0) begin
      n_bad++; $display("FAIL b2b_exclusive: got %0d overlaps want 0", excl_bad);
    end
    n_cmp++;
    if ({mem[14'h0203], mem[14'h0303]} !== {16'hA003, 16'hB003}) begin
      n_bad++; $display("FAIL b2b_mem: got %h %h want a003 b003", mem[14'h0203], mem[14'h0303]);
    end
    tick();
  endtask

  task automatic test_rdata_hold();
    int cyc;
    do_reset();
    preload(14'h2000, 16'h00AA);
    b_if.we = 1'b0; b_if.addr = 14'h2000; b_if.req = 1'b1;
    wait_ack(1'b1, cyc);
    n_cmp++;
    if (cyc !== 2 || b_if.rdata !== 16'h00AA) begin
      n_bad++; $display("FAIL hold_rd1: got latency=%0d rdata=%h want 2 00aa", cyc, b_if.rdata);
    end
    b_if.req = 1'b0;
    tick();
    b_if.we = 1'b1; b_if.wdata = 16'h5555; b_if.req = 1'b1;
    wait_ack(1'b1, cyc);
    n_cmp++;
    if (cyc !== 2 || b_if.rdata !== 16'h00AA) begin
      n_bad++; $display("FAIL hold_wr: got latency=%0d rdata=%h want 2 00aa", cyc, b_if.rdata);
    end
    b_if.req = 1'b0;
    tick();
    n_cmp++;
    if ({b_if.rdata, a_if.rdata} !== {16'h00AA, 16'h0000}) begin
      n_bad++; $display("FAIL hold_after: got b=%h a=%h want 00aa 0000", b_if.rdata, a_if.rdata);
    end
    b_if.we = 1'b0; b_if.req = 1'b1;
    wait_ack(1'b1, cyc);
    n_cmp++;
    if (cyc !== 2 || b_if.rdata !== 16'h5555) begin
      n_bad++; $display("FAIL hold_rd2: got latency=%0d rdata=%h want 2 5555", cyc, b_if.rdata);
    end
    b_if.req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_exec();
    int cyc;
    do_reset();
    preload(14'h0100, 16'h0000);
    a_if.we = 1'b1; a_if.addr = 14'h0100; a_if.wdata = 16'hFFFF; a_if.req = 1'b1;
    tick();
    n_cmp++;
    if ({ram_en, ram_w} !== 2'b11) begin
      n_bad++; $display("FAIL mid_exec: got en=%b w=%b want 1 1", ram_en, ram_w);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ram_w, ram_r, ram_en, busy, a_if.ack, b_if.ack, ram_add, ram_din} !== 36'h0) begin
      n_bad++; $display("FAIL mid_async: got en=%b w=%b busy=%b ack=%b add=%h din=%h want all 0", ram_en, ram_w, busy, a_if.ack, ram_add, ram_din);
    end
    a_if.req = 1'b0;
    tick();
    n_cmp++;
    if ({a_if.ack, busy} !== 2'b00) begin
      n_bad++; $display("FAIL mid_noack: got ack=%b busy=%b want 0 0", a_if.ack, busy);
    end
    rst_n = 1'b1;
    tick();
    a_if.we = 1'b0; a_if.req = 1'b1;
    wait_ack(1'b0, cyc);
    n_cmp++;
    if (cyc !== 2 || (a_if.rdata !== 16'h0000 && a_if.rdata !== 16'hFFFF)) begin
      n_bad++; $display("FAIL mid_readback: got latency=%0d rdata=%h want 2 and 0000 or ffff", cyc, a_if.rdata);
    end
    a_if.req = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_idle: got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_contention();
    test_back_to_back();
    test_rdata_hold();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
